// File: rtl/counter_sequencer.sv
// Programmable interval timer: prescaled WIDTH-bit up-counter with one-shot and
// periodic modes, start/stop/pause sequencing and a registered terminal-count pulse.
module counter_sequencer #(
  parameter int WIDTH       = 4,
  parameter int PRESC_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_load,
  input  logic [WIDTH-1:0]       cfg_period,
  input  logic [PRESC_WIDTH-1:0] cfg_prescale,
  input  logic                   cfg_mode,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  output logic [WIDTH-1:0]       count,
  output logic                   busy,
  output logic                   done,
  output logic                   tc_pulse
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
  logic                   tc_pulse_q, tc_pulse_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic                   mode_q, mode_d;
  logic                   tick;

  assign tick = (presc_cnt_q == presc_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    count_d     = count_q;
    presc_cnt_d = presc_cnt_q;
    tc_pulse_d  = 1'b0;
    period_d    = period_q;
    presc_d     = presc_q;
    mode_d      = mode_q;

    // Configuration may only change while the counter is not sequencing.
    if (cfg_load && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      period_d = cfg_period;
      presc_d  = cfg_prescale;
      mode_d   = cfg_mode;
    end

    case (state_q)
      ST_IDLE: begin
        count_d     = '0;
        presc_cnt_d = '0;
        if (!stop && !pause && start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          count_d     = '0;
          presc_cnt_d = '0;
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else if (tick) begin
          presc_cnt_d = '0;
          if (count_q == period_q) begin
            tc_pulse_d = 1'b1;
            if (mode_q) count_d = '0;
            else        state_d = ST_DONE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);
        end
      end
      ST_PAUSED: begin
        if (stop) begin
          state_d     = ST_IDLE;
          count_d     = '0;
          presc_cnt_d = '0;
        end else if (!pause && start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          count_d     = '0;
          presc_cnt_d = '0;
        end else if (!pause && start) begin
          state_d     = ST_RUN;
          count_d     = '0;
          presc_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      presc_cnt_q <= '0;
      tc_pulse_q  <= 1'b0;
      period_q    <= '1;
      presc_q     <= '0;
      mode_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      presc_cnt_q <= presc_cnt_d;
      tc_pulse_q  <= tc_pulse_d;
      period_q    <= period_d;
      presc_q     <= presc_d;
      mode_q      <= mode_d;
    end
  end

  assign count    = count_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done     = (state_q == ST_DONE);
  assign tc_pulse = tc_pulse_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Table-driven bench for counter_sequencer: per-cycle vectors with hand-derived
// expectations, a scoreboard queue, plus a hand-written asynchronous reset sequence.
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [3:0] cfg_period;
  logic [3:0] cfg_prescale;
  logic       cfg_mode;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       ld;
    logic [3:0] per;
    logic [3:0] pre;
    logic       md;
    logic       st;
    logic       sp;
    logic       pa;
    logic [3:0] exp_count;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_tc;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       tc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  counter_sequencer #(.WIDTH(4), .PRESC_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_load     (cfg_load),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_mode     (cfg_mode),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .count        (count),
    .busy         (busy),
    .done         (done),
    .tc_pulse     (tc_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic ld, input logic [3:0] per,
                              input logic [3:0] pre, input logic md, input logic st,
                              input logic sp, input logic pa, input logic [3:0] ec,
                              input logic eb, input logic ed, input logic et);
    vec_t v;
    v.name = nm; v.ld = ld; v.per = per; v.pre = pre; v.md = md;
    v.st = st; v.sp = sp; v.pa = pa;
    v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed; v.exp_tc = et;
    return v;
  endfunction

  // Config load issued from IDLE: the counter stays idle at zero.
  function automatic vec_t ld(input string nm, input logic [3:0] per, input logic [3:0] pre,
                              input logic md);
    return mk(nm, 1'b1, per, pre, md, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic vec_t cmd(input string nm, input logic st, input logic sp, input logic pa,
                               input logic [3:0] ec, input logic eb, input logic ed,
                               input logic et);
    return mk(nm, 1'b0, 4'd0, 4'd0, 1'b0, st, sp, pa, ec, eb, ed, et);
  endfunction

  function automatic vec_t nop(input string nm, input logic [3:0] ec, input logic eb,
                               input logic ed, input logic et);
    return cmd(nm, 1'b0, 1'b0, 1'b0, ec, eb, ed, et);
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk);
    cfg_load = v.ld; cfg_period = v.per; cfg_prescale = v.pre; cfg_mode = v.md;
    start = v.st; stop = v.sp; pause = v.pa;
    e.name = v.name; e.count = v.exp_count; e.busy = v.exp_busy;
    e.done = v.exp_done; e.tc = v.exp_tc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({got.name, ".count"}, 32'(count), 32'(got.count));
    check({got.name, ".busy"}, 32'(busy), 32'(got.busy));
    check({got.name, ".done"}, 32'(done), 32'(got.done));
    check({got.name, ".tc"}, 32'(tc_pulse), 32'(got.tc));
  endtask

  initial begin
    // Reset-default period (15) and periodic mode, used without any cfg_load.
    vecs.push_back(cmd("dflt_start", 1, 0, 0, 4'd0, 1, 0, 0));
    for (int k = 1; k <= 15; k++) vecs.push_back(nop("dflt_up", 4'(k), 1, 0, 0));
    vecs.push_back(nop("dflt_wrap", 4'd0, 1, 0, 1));
    vecs.push_back(cmd("dflt_stop", 0, 1, 0, 4'd0, 0, 0, 0));

    // Periodic, period 3, no prescale.
    vecs.push_back(ld("per_ld", 4'd3, 4'd0, 1));
    vecs.push_back(cmd("per_start", 1, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(nop("per_c1", 4'd1, 1, 0, 0));
    vecs.push_back(nop("per_c2", 4'd2, 1, 0, 0));
    vecs.push_back(nop("per_c3", 4'd3, 1, 0, 0));
    vecs.push_back(nop("per_wrap1", 4'd0, 1, 0, 1));
    vecs.push_back(nop("per_c1b", 4'd1, 1, 0, 0));
    vecs.push_back(nop("per_c2b", 4'd2, 1, 0, 0));
    vecs.push_back(nop("per_c3b", 4'd3, 1, 0, 0));
    vecs.push_back(nop("per_wrap2", 4'd0, 1, 0, 1));
    vecs.push_back(nop("per_c1c", 4'd1, 1, 0, 0));
    vecs.push_back(cmd("per_stop", 0, 1, 0, 4'd0, 0, 0, 0));

    // One-shot, period 2, prescale 2: count advances every third clock.
    vecs.push_back(ld("os_ld", 4'd2, 4'd2, 0));
    vecs.push_back(cmd("os_start", 1, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(nop("os_p1", 4'd0, 1, 0, 0));
    vecs.push_back(nop("os_p2", 4'd0, 1, 0, 0));
    vecs.push_back(nop("os_c1a", 4'd1, 1, 0, 0));
    vecs.push_back(nop("os_c1b", 4'd1, 1, 0, 0));
    vecs.push_back(nop("os_c1c", 4'd1, 1, 0, 0));
    vecs.push_back(nop("os_c2a", 4'd2, 1, 0, 0));
    vecs.push_back(nop("os_c2b", 4'd2, 1, 0, 0));
    vecs.push_back(nop("os_c2c", 4'd2, 1, 0, 0));
    vecs.push_back(nop("os_done_tc", 4'd2, 0, 1, 1));
    vecs.push_back(nop("os_done_hold", 4'd2, 0, 1, 0));
    vecs.push_back(cmd("os_restart", 1, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(nop("os_restart_p1", 4'd0, 1, 0, 0));
    vecs.push_back(cmd("os_stop", 0, 1, 0, 4'd0, 0, 0, 0));

    // Pause/resume with prescale 1 so the prescaler phase is observable.
    vecs.push_back(ld("pz_ld", 4'd5, 4'd1, 1));
    vecs.push_back(cmd("pz_start", 1, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(nop("pz_e1", 4'd0, 1, 0, 0));
    vecs.push_back(nop("pz_e2", 4'd1, 1, 0, 0));
    vecs.push_back(nop("pz_e3", 4'd1, 1, 0, 0));
    vecs.push_back(nop("pz_e4", 4'd2, 1, 0, 0));
    vecs.push_back(nop("pz_e5", 4'd2, 1, 0, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(cmd("pz_hold", 0, 0, 1, 4'd2, 1, 0, 0));
    vecs.push_back(cmd("pz_resume", 1, 0, 0, 4'd2, 1, 0, 0));
    vecs.push_back(nop("pz_c3a", 4'd3, 1, 0, 0));
    vecs.push_back(nop("pz_c3b", 4'd3, 1, 0, 0));
    vecs.push_back(nop("pz_c4a", 4'd4, 1, 0, 0));
    vecs.push_back(nop("pz_c4b", 4'd4, 1, 0, 0));
    vecs.push_back(nop("pz_c5a", 4'd5, 1, 0, 0));
    vecs.push_back(nop("pz_c5b", 4'd5, 1, 0, 0));
    vecs.push_back(nop("pz_wrap", 4'd0, 1, 0, 1));
    vecs.push_back(nop("pz_c0b", 4'd0, 1, 0, 0));
    vecs.push_back(nop("pz_c1a", 4'd1, 1, 0, 0));
    vecs.push_back(nop("pz_c1b", 4'd1, 1, 0, 0));
    vecs.push_back(cmd("prio_all3", 1, 1, 1, 4'd0, 0, 0, 0));

    // Stop on the terminal tick suppresses tc_pulse.
    vecs.push_back(ld("stc_ld", 4'd1, 4'd0, 1));
    vecs.push_back(cmd("stc_start", 1, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(nop("stc_c1", 4'd1, 1, 0, 0));
    vecs.push_back(cmd("stc_stop", 0, 1, 0, 4'd0, 0, 0, 0));
    vecs.push_back(nop("stc_idle", 4'd0, 0, 0, 0));

    // cfg_load ignored while running, honoured in IDLE.
    vecs.push_back(ld("cg_ld2", 4'd2, 4'd0, 1));
    vecs.push_back(cmd("cg_start", 1, 0, 0, 4'd0, 1, 0, 0));
    vecs.push_back(mk("cg_ld7_run", 1, 4'd7, 4'd0, 1, 0, 0, 0, 4'd1, 1, 0, 0));
    vecs.push_back(nop("cg_c2", 4'd2, 1, 0, 0));
    vecs.push_back(nop("cg_wrap_old", 4'd0, 1, 0, 1));
    vecs.push_back(nop("cg_c1", 4'd1, 1, 0, 0));
    vecs.push_back(nop("cg_c2b", 4'd2, 1, 0, 0));
    vecs.push_back(nop("cg_wrap_old2", 4'd0, 1, 0, 1));
    vecs.push_back(cmd("cg_stop", 0, 1, 0, 4'd0, 0, 0, 0));
    vecs.push_back(ld("cg_ld7_idle", 4'd7, 4'd0, 1));
    vecs.push_back(cmd("cg_start7", 1, 0, 0, 4'd0, 1, 0, 0));
    for (int k = 1; k <= 7; k++) vecs.push_back(nop("cg_up7", 4'(k), 1, 0, 0));
    vecs.push_back(nop("cg_wrap7", 4'd0, 1, 0, 1));
    vecs.push_back(nop("cg_after7", 4'd1, 1, 0, 0));
    vecs.push_back(cmd("cg_stop7", 0, 1, 0, 4'd0, 0, 0, 0));

    // Period 0: every tick is terminal.
    vecs.push_back(ld("p0_ld", 4'd0, 4'd0, 1));
    vecs.push_back(cmd("p0_start", 1, 0, 0, 4'd0, 1, 0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(nop("p0_tc", 4'd0, 1, 0, 1));
    vecs.push_back(cmd("p0_stop", 0, 1, 0, 4'd0, 0, 0, 0));

    reset = 1'b1;
    cfg_load = 1'b0; cfg_period = '0; cfg_prescale = '0; cfg_mode = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    #3;
    check("rst.count", 32'(count), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.tc", 32'(tc_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset between edges while counting.
    apply(ld("ar_ld", 4'd3, 4'd0, 1));
    apply(cmd("ar_start", 1, 0, 0, 4'd0, 1, 0, 0));
    apply(nop("ar_c1", 4'd1, 1, 0, 0));
    apply(nop("ar_c2", 4'd2, 1, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    check("ar_now.count", 32'(count), 32'd0);
    check("ar_now.busy", 32'(busy), 32'd0);
    check("ar_now.done", 32'(done), 32'd0);
    check("ar_now.tc", 32'(tc_pulse), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(nop("ar_idle", 4'd0, 0, 0, 0));
    apply(cmd("ar_start2", 1, 0, 0, 4'd0, 1, 0, 0));
    apply(nop("ar_c1b", 4'd1, 1, 0, 0));

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
